// File: rtl/frame_deframer_if.sv
// Serial-in / byte-out bundle between the descrambler, the deframer and the payload sink.
// Latency: none (wires only). Backpressure: none; the payload sink must take every DATA_VLD_O strobe.
// FRAME_DEFRAMER_ERR_CNT_EN adds SYNC_ERR_CNT_O.
interface frame_deframer_if;
    logic        BIT_I;
    logic [7:0]  DATA_O;
    logic        DATA_VLD_O;
    logic        SOF_O;
    logic        LOCK_O;
`ifdef FRAME_DEFRAMER_ERR_CNT_EN
    logic [15:0] SYNC_ERR_CNT_O;
`endif

    modport master (
        input  BIT_I,
        output DATA_O,
        output DATA_VLD_O,
        output SOF_O,
`ifdef FRAME_DEFRAMER_ERR_CNT_EN
        output SYNC_ERR_CNT_O,
`endif
        output LOCK_O
    );

    modport slave (
        output BIT_I,
        input  DATA_O,
        input  DATA_VLD_O,
        input  SOF_O,
`ifdef FRAME_DEFRAMER_ERR_CNT_EN
        input  SYNC_ERR_CNT_O,
`endif
        input  LOCK_O
    );
endinterface

// File: rtl/frame_deframer.sv
// Sync-word hunt/verify/lock framer that turns a serial bit stream into payload bytes with an SOF marker.
// Latency: each byte is strobed one cycle after its last bit. Backpressure: none; one bit is consumed every cycle.
// FRAME_DEFRAMER_ERR_CNT_EN adds a saturating count of sync misses seen while locked.
module frame_deframer #(
    parameter int                SYNC_W      = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD   = 16'hEB90,
    parameter int                FRAME_BYTES = 8,
    parameter int                LOCK_THR    = 2,
    parameter int                LOSS_THR    = 3
) (
    input  logic             CLK_I,
    input  logic             RST_N_I,
    frame_deframer_if.master bus
);
    localparam int L        = SYNC_W + 8 * FRAME_BYTES;
    localparam int PAY_BITS = 8 * FRAME_BYTES;
    localparam int POS_W    = $clog2(L);
    localparam int FILL_W   = $clog2(SYNC_W);
    localparam int HIT_W    = $clog2(LOCK_THR + 1);
    localparam int MISS_W   = $clog2(LOSS_THR + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [SYNC_W-2:0]   sreg_q,   sreg_d;
    logic [FILL_W-1:0]   fill_q,   fill_d;
    logic [POS_W-1:0]    pos_q,    pos_d;
    logic [HIT_W-1:0]    hits_q,   hits_d;
    logic [MISS_W-1:0]   misses_q, misses_d;
    logic [7:0]          data_q,   data_d;
    logic                vld_q,    vld_d;
    logic                sof_q,    sof_d;
    logic                lock_q,   lock_d;
`ifdef FRAME_DEFRAMER_ERR_CNT_EN
    logic [15:0]         err_q,    err_d;
`endif

    logic [SYNC_W-1:0]   window;
    logic                fill_done;
    logic                sync_hit;
    logic                at_end;
    logic                byte_end;
    logic [POS_W-1:0]    pos_next;

    // The window already includes the bit on BIT_I, so a sync ending this cycle is seen now.
    assign window    = {sreg_q, bus.BIT_I};
    assign fill_done = (fill_q == FILL_W'(SYNC_W - 1));
    assign sync_hit  = fill_done && (window == SYNC_WORD);
    assign at_end    = (pos_q == POS_W'(L - 1));
    assign pos_next  = at_end ? '0 : pos_q + POS_W'(1);
    assign byte_end  = (pos_q < POS_W'(PAY_BITS)) && (pos_q[2:0] == 3'b111);

    always_comb begin
        state_d  = state_q;
        sreg_d   = window[SYNC_W-2:0];
        fill_d   = fill_done ? fill_q : fill_q + FILL_W'(1);
        pos_d    = pos_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        data_d   = data_q;
        vld_d    = 1'b0;
        sof_d    = 1'b0;
`ifdef FRAME_DEFRAMER_ERR_CNT_EN
        err_d    = err_q;
`endif

        case (state_q)
            ST_HUNT: begin
                if (sync_hit) begin
                    pos_d   = '0;
                    hits_d  = HIT_W'(1);
                    state_d = (LOCK_THR == 1) ? ST_LOCK : ST_VERIFY;
                end
            end

            ST_VERIFY: begin
                pos_d = pos_next;
                if (at_end) begin
                    if (sync_hit) begin
                        hits_d = hits_q + HIT_W'(1);
                        if (hits_d == HIT_W'(LOCK_THR)) begin
                            state_d = ST_LOCK;
                        end
                    end else begin
                        hits_d  = '0;
                        state_d = ST_HUNT;
                    end
                end
            end

            ST_LOCK: begin
                pos_d = pos_next;
                // The low byte of the window is exactly the payload byte that just completed.
                if (byte_end) begin
                    data_d = window[7:0];
                    vld_d  = 1'b1;
                    sof_d  = (pos_q == POS_W'(7));
                end
                if (at_end) begin
                    if (sync_hit) begin
                        misses_d = '0;
                    end else begin
`ifdef FRAME_DEFRAMER_ERR_CNT_EN
                        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
`endif
                        if (misses_q + MISS_W'(1) == MISS_W'(LOSS_THR)) begin
                            misses_d = '0;
                            hits_d   = '0;
                            state_d  = ST_HUNT;
                        end else begin
                            misses_d = misses_q + MISS_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase

        lock_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            state_q  <= ST_HUNT;
            sreg_q   <= '0;
            fill_q   <= '0;
            pos_q    <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            sof_q    <= 1'b0;
            lock_q   <= 1'b0;
`ifdef FRAME_DEFRAMER_ERR_CNT_EN
            err_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            fill_q   <= fill_d;
            pos_q    <= pos_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            sof_q    <= sof_d;
            lock_q   <= lock_d;
`ifdef FRAME_DEFRAMER_ERR_CNT_EN
            err_q    <= err_d;
`endif
        end
    end

    assign bus.DATA_O     = data_q;
    assign bus.DATA_VLD_O = vld_q;
    assign bus.SOF_O      = sof_q;
    assign bus.LOCK_O     = lock_q;
`ifdef FRAME_DEFRAMER_ERR_CNT_EN
    assign bus.SYNC_ERR_CNT_O = err_q;
`endif

endmodule
